// File: rtl/enc_pkg.sv
// Shared types and sizing helpers for the keystream sequencer.
// Optional abort port (in the top) is enabled with ENC_ABORT_EN.
package enc_pkg;

    localparam int DATA_W_DEF    = 128;
    localparam int DELAY_DEF     = 4;
    localparam int FRAME_LEN_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PRIME,
        RUN,
        DONE
    } state_e;

    // Width of a counter that holds 0..n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/keystream_delay.sv
// Keystream alignment line: DELAY-deep shift register of generator words.
// Head enters at stage 0; the oldest word is presented on tail_o.
module keystream_delay #(
    parameter int DATA_W = 128,
    parameter int DELAY  = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] head_i,
    output logic [DATA_W-1:0] tail_o
);

    logic [DELAY-1:0][DATA_W-1:0] line_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            line_q <= '0;
        end else if (clr_i) begin
            line_q <= '0;
        end else if (en_i) begin
            line_q[0] <= head_i;
            for (int i = 1; i < DELAY; i++) begin
                line_q[i] <= line_q[i-1];
            end
        end
    end

    assign tail_o = line_q[DELAY-1];

endmodule

// File: rtl/keystream_sequencer.sv
// Stream-cipher controller: seeds/primes the PRBS generator, XORs plaintext with
// aligned keystream and frames FRAME_LEN blocks. ENC_ABORT_EN adds an abort input.
module keystream_sequencer import enc_pkg::*; #(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DELAY     = DELAY_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        start,
`ifdef ENC_ABORT_EN
    input  logic                        abort,
`endif
    output logic                        prbs_load,
    output logic                        prbs_step,
    input  logic [DATA_W-1:0]           prbs_in,
    input  logic                        pt_valid,
    output logic                        pt_ready,
    input  logic [DATA_W-1:0]           pt_data,
    output logic                        ct_valid,
    input  logic                        ct_ready,
    output logic [DATA_W-1:0]           ct_data,
    output logic [cnt_w(FRAME_LEN)-1:0] block_count,
    output logic                        busy,
    output logic                        frame_done
);

    localparam int CW = cnt_w(FRAME_LEN);
    localparam int PW = cnt_w(DELAY);

    state_e            state_q, state_d;
    logic [PW-1:0]     prime_q, prime_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ct_valid_q, ct_valid_d;
    logic [DATA_W-1:0] ct_data_q, ct_data_d;
    logic [DATA_W-1:0] tail;
    logic              accept, line_en, line_clr, abort_w;

`ifdef ENC_ABORT_EN
    assign abort_w = abort && (state_q != IDLE);
`else
    assign abort_w = 1'b0;
`endif

    keystream_delay #(.DATA_W(DATA_W), .DELAY(DELAY)) u_line (
        .clk    (clk),
        .n_rst  (n_rst),
        .en_i   (line_en),
        .clr_i  (line_clr),
        .head_i (prbs_in),
        .tail_o (tail)
    );

    always_comb begin
        state_d    = state_q;
        prime_d    = prime_q;
        count_d    = count_q;
        ct_valid_d = ct_valid_q;
        ct_data_d  = ct_data_q;
        pt_ready   = 1'b0;
        prbs_load  = 1'b0;
        prbs_step  = 1'b0;
        frame_done = 1'b0;
        line_en    = 1'b0;
        line_clr   = 1'b0;
        accept     = 1'b0;

        if (ct_valid_q && ct_ready) ct_valid_d = 1'b0;

        unique case (state_q)
            IDLE: if (start) state_d = LOAD;
            LOAD: begin
                prbs_load = 1'b1;
                prime_d   = '0;
                state_d   = PRIME;
            end
            PRIME: begin
                prbs_step = 1'b1;
                line_en   = 1'b1;
                prime_d   = prime_q + 1'b1;
                if (prime_q == PW'(DELAY - 1)) state_d = RUN;
            end
            RUN: begin
                pt_ready = !ct_valid_q || ct_ready;
                accept   = pt_ready && pt_valid;
                // The line only moves with a generator step, keeping block i on word i.
                if (accept) begin
                    ct_data_d  = pt_data ^ tail;
                    ct_valid_d = 1'b1;
                    prbs_step  = 1'b1;
                    line_en    = 1'b1;
                    if (count_q == CW'(FRAME_LEN - 1)) begin
                        count_d = '0;
                        state_d = DONE;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (!ct_valid_q) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort_w) begin
            state_d    = IDLE;
            prime_d    = '0;
            count_d    = '0;
            ct_valid_d = 1'b0;
            ct_data_d  = ct_data_q;
            pt_ready   = 1'b0;
            prbs_load  = 1'b0;
            prbs_step  = 1'b0;
            frame_done = 1'b0;
            line_en    = 1'b0;
            line_clr   = 1'b1;
            accept     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            prime_q    <= '0;
            count_q    <= '0;
            ct_valid_q <= 1'b0;
            ct_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            prime_q    <= prime_d;
            count_q    <= count_d;
            ct_valid_q <= ct_valid_d;
            ct_data_q  <= ct_data_d;
        end
    end

    assign ct_valid    = ct_valid_q;
    assign ct_data     = ct_data_q;
    assign block_count = count_q;
    assign busy        = (state_q != IDLE);

endmodule
